// File: rtl/gpi_debounce_if.sv
// Bus between the board pins and the gp_i input conditioning block.
// master: the side that drives raw pins and the interrupt controls.
// slave:  the debounce block.
interface gpi_debounce_if #(
   parameter int unsigned Width = 20
);

   logic [Width-1:0] gpi_raw_i;
   logic [Width-1:0] gpi_db_o;
   logic [Width-1:0] gpi_rise_o;
   logic [Width-1:0] gpi_fall_o;
   logic [Width-1:0] irq_en_i;
   logic [Width-1:0] pend_clr_i;
   logic [Width-1:0] pend_o;
   logic             irq_o;

   modport master (
      output gpi_raw_i,
      output irq_en_i,
      output pend_clr_i,
      input  gpi_db_o,
      input  gpi_rise_o,
      input  gpi_fall_o,
      input  pend_o,
      input  irq_o
   );

   modport slave (
      input  gpi_raw_i,
      input  irq_en_i,
      input  pend_clr_i,
      output gpi_db_o,
      output gpi_rise_o,
      output gpi_fall_o,
      output pend_o,
      output irq_o
   );

endinterface

// File: rtl/gpi_debounce.sv
// gpi_debounce: per-bit synchroniser, bounce filter and edge-pulse generator
// for the board buttons/switches feeding gp_i ({BTN, SW}).
// Optional macro GPI_DEBOUNCE_IRQ_EN adds sticky change-pending bits and an
// interrupt output. With the macro undefined, pend_o and irq_o are tied low
// and irq_en_i / pend_clr_i are ignored.
module gpi_debounce #(
   parameter int unsigned Width          = 20,
   parameter int unsigned DebounceCycles = 50000,
   parameter int unsigned CntWidth       = $clog2(DebounceCycles + 1)
) (
   input logic           clk_sys_i,
   input logic           rst_sys_i,
   gpi_debounce_if.slave bus
);

   // Last counter value before the filtered level is allowed to follow sync2.
   localparam logic [CntWidth-1:0] CntMax = CntWidth'(DebounceCycles - 1);

   (* ASYNC_REG = "TRUE" *) logic [Width-1:0] sync1_q;
   logic [Width-1:0] sync2_q;

   logic [CntWidth-1:0] cnt_q [Width];
   logic [CntWidth-1:0] cnt_d [Width];

   logic [Width-1:0] db_q;
   logic [Width-1:0] db_d;
   logic [Width-1:0] rise_q;
   logic [Width-1:0] rise_d;
   logic [Width-1:0] fall_q;
   logic [Width-1:0] fall_d;

   // Two-flop synchroniser; the only logic that sees the raw pins.
   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= bus.gpi_raw_i;
         sync2_q <= sync1_q;
      end
   end

   // Stability filter: any cycle where sync2 agrees with db restarts the run.
   always_comb begin
      db_d   = db_q;
      rise_d = '0;
      fall_d = '0;
      for (int unsigned i = 0; i < Width; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               db_d[i]   = sync2_q[i];
               rise_d[i] = sync2_q[i];
               fall_d[i] = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CntWidth'(1);
            end
         end
      end
   end

   // Counter, filtered level and one-cycle edge pulses.
   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i) begin
         for (int unsigned i = 0; i < Width; i++) begin
            cnt_q[i] <= '0;
         end
         db_q   <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         for (int unsigned i = 0; i < Width; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         db_q   <= db_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign bus.gpi_db_o   = db_q;
   assign bus.gpi_rise_o = rise_q;
   assign bus.gpi_fall_o = fall_q;

`ifdef GPI_DEBOUNCE_IRQ_EN
   logic [Width-1:0] pend_q;

   // Sticky pending: a masked edge pulse sets, write-1 clears, set wins.
   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i) begin
         pend_q <= '0;
      end else begin
         pend_q <= ((rise_q | fall_q) & bus.irq_en_i) | (pend_q & ~bus.pend_clr_i);
      end
   end

   assign bus.pend_o = pend_q;
   assign bus.irq_o  = |pend_q;
`else
   logic unused_irq_inputs;

   // Interrupt controls kept on the port list for a uniform top level.
   assign unused_irq_inputs = ^{bus.irq_en_i, bus.pend_clr_i};
   assign bus.pend_o        = '0;
   assign bus.irq_o         = 1'b0;
`endif

endmodule

// File: tb/tb_gpi_debounce.sv
// Testbench for gpi_debounce with DebounceCycles=4, Width=20.
module tb_gpi_debounce;

   localparam int unsigned W  = 20;
   localparam int unsigned DC = 4;

   typedef struct packed {
      logic [W-1:0] raw;
      logic [W-1:0] db;
      logic [W-1:0] rise;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state (values visible after the most recent edge).
   logic [W-1:0] m_pipe [2];
   logic [W-1:0] m_hist [DC];
   logic [W-1:0] m_db;
   logic [W-1:0] m_rise;
   logic [W-1:0] m_fall;
   logic [W-1:0] m_pend;

   vec_t bit16_tbl  [8];
   vec_t bounce_tbl [12];

   gpi_debounce_if #(.Width(W)) bus ();

   gpi_debounce #(
      .Width         (W),
      .DebounceCycles(DC)
   ) dut (
      .clk_sys_i(clk),
      .rst_sys_i(rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: db follows sync2 once the last DC sync2 samples all disagreed with it.
   task automatic model_step();
      logic [W-1:0] s2;
      logic [W-1:0] upd;
      if (rst) begin
         m_pipe[0] = '0;
         m_pipe[1] = '0;
         for (int j = 0; j < DC; j++) m_hist[j] = '0;
         m_db   = '0;
         m_rise = '0;
         m_fall = '0;
         m_pend = '0;
      end else begin
`ifdef GPI_DEBOUNCE_IRQ_EN
         m_pend = ((m_rise | m_fall) & bus.irq_en_i) | (m_pend & ~bus.pend_clr_i);
`else
         m_pend = '0;
`endif
         s2        = m_pipe[0];
         m_pipe[0] = m_pipe[1];
         m_pipe[1] = bus.gpi_raw_i;
         for (int j = 0; j < DC - 1; j++) m_hist[j] = m_hist[j+1];
         m_hist[DC-1] = s2;
         upd = '1;
         for (int j = 0; j < DC; j++) upd = upd & (m_hist[j] ^ m_db);
         m_rise = upd & s2;
         m_fall = upd & ~s2;
         m_db   = m_db ^ upd;
      end
   endtask

   // One clock: predict, clock, then compare every output against the model.
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check("model_db",   32'(bus.gpi_db_o),   32'(m_db));
      check("model_rise", 32'(bus.gpi_rise_o), 32'(m_rise));
      check("model_fall", 32'(bus.gpi_fall_o), 32'(m_fall));
      check("model_pend", 32'(bus.pend_o),     32'(m_pend));
      check("model_irq",  32'(bus.irq_o),      32'(|m_pend));
   endtask

   initial begin
      int rise_cnt;
      int fall_cnt;
      logic [W-1:0] exp_pend;

      for (int k = 0; k < 8; k++) begin
         bit16_tbl[k].raw  = 20'h10000;
         bit16_tbl[k].db   = (k >= 5) ? 20'h10000 : 20'h00000;
         bit16_tbl[k].rise = (k == 5) ? 20'h10000 : 20'h00000;
      end
      for (int k = 0; k < 12; k++) begin
         bounce_tbl[k].raw  = (k == 3) ? 20'h10000 : 20'h10008;
         bounce_tbl[k].db   = (k >= 9) ? 20'h10008 : 20'h10000;
         bounce_tbl[k].rise = (k == 9) ? 20'h00008 : 20'h00000;
      end

      rst            = 1'b1;
      bus.gpi_raw_i  = '0;
      bus.irq_en_i   = '0;
      bus.pend_clr_i = '0;

      // Reset state
      for (int k = 0; k < 3; k++) tick();
      check("reset_db",   32'(bus.gpi_db_o),   32'h0);
      check("reset_rise", 32'(bus.gpi_rise_o), 32'h0);
      check("reset_irq",  32'(bus.irq_o),      32'h0);

      // Idle with all-zero pins
      rst = 1'b0;
      for (int k = 0; k < 50; k++) begin
         tick();
         check("idle_db",   32'(bus.gpi_db_o),                    32'h0);
         check("idle_edge", 32'(bus.gpi_rise_o | bus.gpi_fall_o), 32'h0);
         check("idle_irq",  32'(bus.irq_o),                       32'h0);
      end

      // BTN0 (bit16) rise latency
      for (int k = 0; k < 8; k++) begin
         bus.gpi_raw_i = bit16_tbl[k].raw;
         tick();
         check("bit16_db",   32'(bus.gpi_db_o),   32'(bit16_tbl[k].db));
         check("bit16_rise", 32'(bus.gpi_rise_o), 32'(bit16_tbl[k].rise));
         check("bit16_fall", 32'(bus.gpi_fall_o), 32'h0);
      end

      // Bounce on bit3: 3-cycle high, 1-cycle low, then held high
      for (int k = 0; k < 12; k++) begin
         bus.gpi_raw_i = bounce_tbl[k].raw;
         tick();
         check("bounce_db",   32'(bus.gpi_db_o),   32'(bounce_tbl[k].db));
         check("bounce_rise", 32'(bus.gpi_rise_o), 32'(bounce_tbl[k].rise));
         check("bounce_fall", 32'(bus.gpi_fall_o), 32'h0);
      end

      // Reset mid-count on bit0 discards the partial count
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.gpi_raw_i = '0;
      for (int k = 0; k < 10; k++) tick();
      bus.gpi_raw_i = 20'h00001;
      for (int k = 0; k < 5; k++) tick();
      rst = 1'b1;
      tick();
      check("rst_mid_db",   32'(bus.gpi_db_o),   32'h0);
      check("rst_mid_rise", 32'(bus.gpi_rise_o), 32'h0);
      check("rst_mid_fall", 32'(bus.gpi_fall_o), 32'h0);
      check("rst_mid_pend", 32'(bus.pend_o),     32'h0);
      check("rst_mid_irq",  32'(bus.irq_o),      32'h0);
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check("rst_restart_db0",   32'(bus.gpi_db_o[0]),   (k >= 6) ? 32'h1 : 32'h0);
         check("rst_restart_rise0", 32'(bus.gpi_rise_o[0]), (k == 6) ? 32'h1 : 32'h0);
      end

      // All 20 bits change in one cycle
      bus.gpi_raw_i = '0;
      for (int k = 0; k < 10; k++) tick();
      bus.gpi_raw_i = 20'hFFFFF;
      rise_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.gpi_rise_o != '0) begin
            rise_cnt++;
            check("all_rise_val", 32'(bus.gpi_rise_o), 32'h000FFFFF);
            check("all_rise_cyc", 32'(k), 32'd5);
         end
      end
      check("all_rise_cnt", 32'(rise_cnt), 32'd1);
      bus.gpi_raw_i = '0;
      fall_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.gpi_fall_o != '0) begin
            fall_cnt++;
            check("all_fall_val", 32'(bus.gpi_fall_o), 32'h000FFFFF);
            check("all_fall_cyc", 32'(k), 32'd5);
         end
      end
      check("all_fall_cnt", 32'(fall_cnt), 32'd1);

      // Pending / interrupt behaviour on bit16, bit0 masked
`ifdef GPI_DEBOUNCE_IRQ_EN
      exp_pend = 20'h10000;
`else
      exp_pend = 20'h00000;
`endif
      bus.irq_en_i  = 20'h10000;
      bus.gpi_raw_i = 20'h10000;
      for (int k = 0; k < 6; k++) tick();
      check("irq_pulse_rise", 32'(bus.gpi_rise_o), 32'h00010000);
      check("irq_before_set", 32'(bus.pend_o), 32'h0);
      tick();
      check("irq_pend_set", 32'(bus.pend_o), 32'(exp_pend));
      check("irq_out_set",  32'(bus.irq_o),  32'(|exp_pend));
      bus.gpi_raw_i = 20'h00000;
      for (int k = 0; k < 6; k++) tick();
      check("irq_pulse_fall", 32'(bus.gpi_fall_o), 32'h00010000);
      bus.pend_clr_i = 20'h10000;
      tick();
      bus.pend_clr_i = 20'h00000;
      check("irq_set_wins", 32'(bus.pend_o), 32'(exp_pend));
      tick();
      check("irq_still_set", 32'(bus.pend_o), 32'(exp_pend));
      bus.pend_clr_i = 20'h10000;
      tick();
      bus.pend_clr_i = 20'h00000;
      check("irq_cleared_pend", 32'(bus.pend_o), 32'h0);
      check("irq_cleared_irq",  32'(bus.irq_o),  32'h0);
      bus.pend_clr_i = 20'h10000;
      tick();
      bus.pend_clr_i = 20'h00000;
      check("irq_clear_idle", 32'(bus.pend_o), 32'h0);
      bus.gpi_raw_i = 20'h00001;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("irq_masked_bit0", 32'(bus.pend_o), 32'h0);
      end

      // Randomised pins, masks, clears and occasional resets against the model
      for (int k = 0; k < 3000; k++) begin
         for (int b = 0; b < W; b++) begin
            if ($urandom_range(0, 5) == 0) bus.gpi_raw_i[b] = ~bus.gpi_raw_i[b];
         end
         if ($urandom_range(0, 49) == 0) bus.irq_en_i = W'($urandom);
         bus.pend_clr_i = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
         rst = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
